// File: rtl/memory_pkg.sv
// Shared definitions for the memory tank sequencer: FSM states, timing defaults,
// slot-address width and the gate pattern used during a transfer.
package memory_pkg;

    localparam int DIGITS_PER_MINOR_DEF = 18;
    localparam int SHORT_WORDS_DEF      = 32;
    localparam int SLOT_W               = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER,
        DONE
    } tank_state_t;

    // Gate pattern {tank_out, tank_in, tank_clr}: a write must stop recirculation
    // while it drives the new data in, a read only opens the output gate.
    function automatic logic [2:0] gate_mask(input logic wr);
        return wr ? 3'b011 : 3'b100;
    endfunction

endpackage

// File: rtl/memory_tank_timer.sv
// Free-running digit and slot counters for the circulating tank; exports the slot
// at the tank output plus strobes for the first and last digit of each minor cycle.
module memory_tank_timer
    import memory_pkg::*;
#(
    parameter int DIGITS_PER_MINOR = DIGITS_PER_MINOR_DEF,
    parameter int SHORT_WORDS      = SHORT_WORDS_DEF
) (
    input  logic              r1_clk,
    input  logic              r1_rst_n,
    output logic [SLOT_W-1:0] pos,
    output logic [SLOT_W-1:0] pos_next,
    output logic              digit0,
    output logic              slot_end
);

    localparam int DIG_W = (DIGITS_PER_MINOR > 1) ? $clog2(DIGITS_PER_MINOR) : 1;
    localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS_PER_MINOR - 1);
    localparam logic [SLOT_W-1:0] POS_LAST = SLOT_W'(SHORT_WORDS - 1);

    logic [DIG_W-1:0] digit;

    assign digit0   = (digit == '0);
    assign slot_end = (digit == DIG_LAST);
    assign pos_next = (pos == POS_LAST) ? '0 : pos + SLOT_W'(1);

    // The slot advances only when the last digit of the minor cycle has passed.
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            digit <= '0;
            pos   <= '0;
        end else if (slot_end) begin
            digit <= '0;
            pos   <= pos_next;
        end else begin
            digit <= digit + DIG_W'(1);
        end
    end

endmodule

// File: rtl/memory_tank_sequencer.sv
// Arbitrates two requesters onto one circulating memory tank and times the gates.
// Optional macro MEMORY_TANK_SEQ_MONITOR_EN adds the monitor / monitor_hit outputs.
module memory_tank_sequencer
    import memory_pkg::*;
#(
    parameter int DIGITS_PER_MINOR = DIGITS_PER_MINOR_DEF,
    parameter int SHORT_WORDS      = SHORT_WORDS_DEF
) (
    input  logic              r1_clk,
    input  logic              r1_rst_n,
    input  logic [1:0]        req,
    input  logic [SLOT_W-1:0] addr0,
    input  logic [SLOT_W-1:0] addr1,
    input  logic              long0,
    input  logic              long1,
    input  logic              wr0,
    input  logic              wr1,
    output logic [1:0]        ack,
    output logic              err,
    output logic              tank_out,
    output logic              tank_in,
    output logic              tank_clr,
    output logic [SLOT_W-1:0] pos,
    output logic              busy
`ifdef MEMORY_TANK_SEQ_MONITOR_EN
    ,
    output logic              monitor,
    output logic              monitor_hit
`endif
);

    tank_state_t       state;
    logic [SLOT_W-1:0] pos_next;
    logic              digit0;
    logic              slot_end;

    logic              grant1;
    logic              last_one;
    logic [SLOT_W-1:0] addr_q;
    logic              long_q;
    logic              wr_q;
    logic              slots_left;

    logic              pick1;
    logic [SLOT_W-1:0] sel_addr;
    logic              sel_long;
    logic              sel_wr;

    memory_tank_timer #(
        .DIGITS_PER_MINOR(DIGITS_PER_MINOR),
        .SHORT_WORDS     (SHORT_WORDS)
    ) u_timer (
        .r1_clk  (r1_clk),
        .r1_rst_n(r1_rst_n),
        .pos     (pos),
        .pos_next(pos_next),
        .digit0  (digit0),
        .slot_end(slot_end)
    );

    // Round-robin: requester 1 wins a tie only when requester 0 was served last.
    always_comb begin
        pick1    = req[1] & (~req[0] | ~last_one);
        sel_addr = pick1 ? addr1 : addr0;
        sel_long = pick1 ? long1 : long0;
        sel_wr   = pick1 ? wr1   : wr0;
    end

    // Entry into XFER is decided one cycle early (last digit of the preceding slot)
    // so the registered gates open exactly on digit 0 of the addressed slot.
    always_ff @(posedge r1_clk or negedge r1_rst_n) begin
        if (!r1_rst_n) begin
            state      <= IDLE;
            grant1     <= 1'b0;
            last_one   <= 1'b1;
            addr_q     <= '0;
            long_q     <= 1'b0;
            wr_q       <= 1'b0;
            slots_left <= 1'b0;
            ack        <= 2'b00;
            err        <= 1'b0;
            {tank_out, tank_in, tank_clr} <= 3'b000;
        end else begin
            ack <= 2'b00;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant1   <= pick1;
                        last_one <= pick1;
                        addr_q   <= sel_addr;
                        long_q   <= sel_long;
                        wr_q     <= sel_wr;
                        if (sel_long && sel_addr[0]) begin
                            state <= DONE;
                            ack   <= pick1 ? 2'b10 : 2'b01;
                            err   <= 1'b1;
                        end else if (slot_end && (pos_next == sel_addr)) begin
                            state      <= XFER;
                            slots_left <= sel_long;
                            {tank_out, tank_in, tank_clr} <= gate_mask(sel_wr);
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (slot_end && (pos_next == addr_q)) begin
                        state      <= XFER;
                        slots_left <= long_q;
                        {tank_out, tank_in, tank_clr} <= gate_mask(wr_q);
                    end
                end
                XFER: begin
                    if (slot_end) begin
                        if (slots_left) begin
                            slots_left <= 1'b0;
                        end else begin
                            state <= DONE;
                            ack   <= grant1 ? 2'b10 : 2'b01;
                            {tank_out, tank_in, tank_clr} <= 3'b000;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef MEMORY_TANK_SEQ_MONITOR_EN
    assign monitor     = digit0;
    assign monitor_hit = (state == XFER);
`else
    logic unused_digit0;
    assign unused_digit0 = digit0;
`endif

endmodule

// File: doc/memory_tank_sequencer.md
MEMORY_TANK_SEQUENCER -- requirements
Module: memory_tank_sequencer

Interface
REQ-001 SHALL have parameter DIGITS_PER_MINOR, default 18, meaning clock periods per minor cycle (17 data digits plus 1 gap).
REQ-002 SHALL have parameter SHORT_WORDS, default 32, meaning short-word slots circulating in one tank (16 long words).
REQ-003 r1_clk  input  1  digit-rate clock; all state changes on its rising edge.
REQ-004 r1_rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester access request, bit0 = order fetch, bit1 = operand; held until ack.
REQ-006 addr0, addr1  input  5 each  short-word slot address per requester.
REQ-007 long0, long1  input  1 each  1 = long-word access covering slots addr, addr+1.
REQ-008 wr0, wr1  input  1 each  1 = write (replace circulating data), 0 = read.
REQ-009 ack  output  2  one-cycle completion pulse per requester.
REQ-010 err  output  1  one-cycle pulse coincident with ack for a rejected request.
REQ-011 tank_out  output  1  read gate to tank (r1_down_t3_out style).
REQ-012 tank_in  output  1  write gate to tank.
REQ-013 tank_clr  output  1  recirculation-inhibit gate to tank.
REQ-014 pos  output  5  short-word slot currently at the tank output.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Digit counter SHALL count 0..DIGITS_PER_MINOR-1 and wrap; slot counter pos SHALL increment, modulo SHORT_WORDS, when the digit counter wraps.
REQ-017 Counters SHALL run continuously, independent of the FSM.
REQ-018 FSM states SHALL be IDLE, WAIT, XFER, DONE.
REQ-019 IDLE: with any req bit set, grant one requester, latch its addr/long/wr, go to WAIT next cycle.
REQ-020 When both req bits are set in the same cycle, grant SHALL go to the requester not granted last (round-robin); after reset, bit0 wins.
REQ-021 A long request with odd addr SHALL be rejected: go to DONE directly, no gates asserted; DONE asserts err.
REQ-022 WAIT -> XFER on the cycle where the digit counter is 0 and pos equals the latched addr.
REQ-023 If addr already matches at digit 0 on the first WAIT cycle, XFER SHALL begin that cycle; otherwise WAIT lasts up to one full circulation (SHORT_WORDS*DIGITS_PER_MINOR cycles).
REQ-024 XFER SHALL last DIGITS_PER_MINOR cycles (short) or 2*DIGITS_PER_MINOR cycles (long), then go to DONE.
REQ-025 During XFER: read asserts tank_out only; write asserts tank_in and tank_clr together; all gates SHALL be low outside XFER.
REQ-026 DONE SHALL last one cycle, pulse ack for the granted requester, then return to IDLE.
REQ-027 Requests arriving in non-IDLE states SHALL wait and be considered in the next IDLE cycle; the granted requester's req SHALL be ignored in the DONE cycle.
REQ-028 Long access at addr 30 SHALL cover slots 30, 31; pos wraps 31 -> 0 with no special handling.

Reset
REQ-029 Asserting r1_rst_n low SHALL immediately force: FSM IDLE, digit counter 0, pos 0, ack 0, err 0, all gates 0, busy 0, round-robin pointer to bit0.
REQ-030 Reset mid-XFER SHALL abort without ack; the requester re-issues the request after reset.

Configuration
REQ-031 Macro MEMORY_TANK_SEQ_MONITOR_EN defined: add output monitor (1 bit) pulsing high for the digit-0 cycle of every slot, plus output monitor_hit (1 bit) high during XFER, for the CRT tank monitor.
REQ-032 Macro undefined: neither port nor associated logic SHALL exist; all other behaviour is identical.

Structure
REQ-033 A shared package memory_pkg SHALL hold the FSM state enum, the DIGITS_PER_MINOR and SHORT_WORDS defaults, and the slot-address width.
REQ-034 One sub-module, memory_tank_timer, SHALL contain the digit and slot counters and export pos and the digit-0 strobe.

Verification
REQ-035 Reset released, req=01, addr0=5, short, read -> tank_out high for 18 cycles starting at the first digit-0 with pos=5; ack=01 on the next cycle.
REQ-036 req=11 simultaneously after reset -> requester 0 served first, then requester 1; on a second simultaneous pair, requester 1 is served first.
REQ-037 Long write, addr1=30 -> tank_in and tank_clr high for 36 cycles spanning pos 30, 31; ack=10 afterwards; pos reads 0 after the span.
REQ-038 Long read, addr0=7 -> no gates asserted, ack=01 and err=1 two cycles after the grant.
REQ-039 r1_rst_n pulsed low at cycle 10 of XFER -> gates drop at once, no ack, pos=0; the same request then completes normally.
REQ-040 Request issued at digit 0 with pos already equal to addr -> XFER starts in the first WAIT cycle only if still aligned, otherwise after one full 576-cycle circulation.
